cdu_count_receiver: RTL and testbench
=====================================

Name: cdu_count_receiver

Overview:
- Computer-side end of the CDU angle interface.
- Generates the CLOCKH reference square wave that the CDU consumes.
- Accepts the CDU's asynchronous angle-increment pulses (plus/minus) and accumulates them into a 15-bit two's-complement angle counter.
- Issues the CCDUZ zero command, supports snapshot reads, and reports counter wrap events.

Parameters:
CLKH_HALF_DIV, 500, clk cycles per CLOCKH half-period (51.2 MHz clk -> 51.2 kHz CLOCKH); minimum value 2
ZERO_LEN, 2048, clk cycles CCDUZ is held high per zero command; minimum value 1
CNT_W, 15, angle counter width in bits

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
PCDU  input  1  async plus-increment pulse from CDU (one count per rising edge)
MCDU  input  1  async minus-increment pulse from CDU (one count per rising edge)
zero_req  input  1  single-cycle request to zero the counter and command CDU zero
rd_req  input  1  single-cycle snapshot read request
CLOCKH  output  1  reference square wave to CDU, 50% duty
CCDUZ  output  1  CDU zero command, high while zeroing
busy  output  1  high while the zeroing sequence is active
rd_ack  output  1  one-cycle strobe; rd_data valid in this cycle
rd_data  output  CNT_W  counter snapshot
wrap  output  1  one-cycle strobe on a counter wrap (0x3FFF->0x4000 or 0x4000->0x3FFF as signed)

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Values while rst_n is low and after release:
  - counter=0, CLOCKH=0, CCDUZ=0, busy=0, rd_ack=0, rd_data=0, wrap=0.
  - Synchronizers and edge registers=0. Divider count=0.
- CLOCKH: free-running divider that toggles every CLKH_HALF_DIV clk cycles. First toggle occurs CLKH_HALF_DIV cycles after reset release. It is unaffected by zeroing.
- Input path:
  - PCDU and MCDU each pass through a 2-flop synchronizer and then a previous-value register.
  - An increment event occurs when the synchronized value is 1 and the previous value is 0.
  - Latency: the counter changes on the 3rd rising clk edge after the first edge that samples the pin high.
- Counter update, evaluated per cycle:
  - Plus only: counter+1, modulo 2^CNT_W.
  - Minus only: counter-1, modulo 2^CNT_W.
  - Both in the same cycle: the two events cancel and the counter is unchanged.
  - Neither: the counter holds.
- Wrap reporting:
  - Plus at 0x3FFF -> 0x4000 or minus at 0x4000 -> 0x3FFF: wrap pulses high for 1 cycle, registered with the counter update.
  - 0x7FFF <-> 0x0000 is ordinary -1/0 arithmetic and does not assert wrap.
- FSM states: IDLE, ZEROING.
  - IDLE, zero_req=1: counter<=0 on the same edge, CCDUZ<=1, busy<=1, load a down-counter with ZERO_LEN, go to ZEROING.
  - ZEROING: all increment events are discarded and the counter stays 0. zero_req is ignored. The down-counter decrements each cycle.
  - ZEROING, down-counter reaches 1: CCDUZ<=0, busy<=0, go to IDLE. CCDUZ is therefore high for exactly ZERO_LEN cycles.
  - zero_req and an increment in the same IDLE cycle: the zero takes priority and the result is counter=0.
- Read port:
  - rd_req at cycle N gives rd_ack=1 at cycle N+1, with rd_data = counter value after edge N, so the update from cycle N is included.
  - rd_data holds its value until the next read.
  - Reads are allowed in any state. A read during ZEROING returns 0.
  - Back-to-back rd_req produces back-to-back rd_ack.
- Reset mid-zeroing: all state is aborted immediately. CCDUZ drops asynchronously and the FSM returns to IDLE.
- Pulse rate: inputs are guaranteed ≥3 clk cycles high and ≥3 clk cycles low. Narrower pulses may be lost, and no error is flagged.

Optional Feature:
- Macro: CDU_GLITCH_FILTER_EN.
- Defined:
  - Each synchronized input passes through a 3-sample majority/stability filter. The filtered value changes only after 3 consecutive identical synchronized samples.
  - Latency becomes 5 clk edges from pin to counter.
  - A high pulse shorter than 3 cycles produces no count.
- Undefined: no filter, and latency is 3 edges as above.

Test Plan:
- Reset release, then run 2*CLKH_HALF_DIV*4 cycles -> CLOCKH toggles exactly every 500 cycles, 4 full periods, and all other outputs stay 0.
- 10 PCDU pulses, then 3 MCDU pulses, then rd_req -> rd_ack next cycle with rd_data=0x0007.
- Preload to 0x3FFF via 0x3FFF PCDU pulses, then 1 PCDU -> counter=0x4000 and wrap high for exactly 1 cycle. Then 1 MCDU -> 0x3FFF and wrap pulses again. A 0x0000->0x7FFF transition gives no wrap.
- PCDU and MCDU rising together (same synchronized cycle) 5 times -> counter unchanged at 0.
- Counter=0x0123, then zero_req -> CCDUZ and busy high for exactly 2048 cycles. PCDU pulses during this window are ignored, and a read returns 0x0000. A second zero_req mid-window does not extend it. A PCDU pulse after busy falls -> 0x0001.
- rst_n low at cycle 100 of zeroing -> CCDUZ=0 and busy=0 immediately. With CDU_GLITCH_FILTER_EN defined, a 2-cycle PCDU pulse gives count 0 and a 4-cycle pulse gives count 1.

Source files
------------

// File: rtl/cdu_count_receiver.sv
// rtl/cdu_count_receiver.sv - CDU angle counter receiver with CLOCKH generator, zeroing FSM and snapshot read (optional CDU_GLITCH_FILTER_EN)
module cdu_count_receiver #(
    parameter int CLKH_HALF_DIV = 500,
    parameter int ZERO_LEN      = 2048,
    parameter int CNT_W         = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PCDU,
    input  logic             MCDU,
    input  logic             zero_req,
    input  logic             rd_req,
    output logic             CLOCKH,
    output logic             CCDUZ,
    output logic             busy,
    output logic             rd_ack,
    output logic [CNT_W-1:0] rd_data,
    output logic             wrap
);

    localparam int DW = (CLKH_HALF_DIV > 2) ? $clog2(CLKH_HALF_DIV) : 1;
    localparam int ZW = $clog2(ZERO_LEN + 1);
    localparam logic [CNT_W-1:0] MID    = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] MID_M1 = MID - CNT_W'(1);

    typedef enum logic {IDLE, ZEROING} state_t;

    state_t          state, state_next;
    logic [ZW-1:0]   zcnt, zcnt_next;
    logic [DW-1:0]   div_cnt;
    logic [1:0]      sync1, sync2;   // bit 0 = plus, bit 1 = minus
    logic [1:0]      ev;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic            wrap_next;
    logic            zero_start;

    // Free-running CLOCKH divider, independent of zeroing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            CLOCKH  <= 1'b0;
        end else if (div_cnt == DW'(CLKH_HALF_DIV - 1)) begin
            div_cnt <= '0;
            CLOCKH  <= ~CLOCKH;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // Two-flop synchronizers for the asynchronous increment pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {MCDU, PCDU};
            sync2 <= sync1;
        end
    end

`ifdef CDU_GLITCH_FILTER_EN
    logic [1:0] hist1, hist2, filt, filt_next;

    // Filtered level follows the synchronized input only after 3 identical samples
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            filt_next[i] = ((sync2[i] == hist1[i]) && (hist1[i] == hist2[i])) ? sync2[i] : filt[i];
        end
    end

    // Sample history and filtered-level register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist1 <= '0;
            hist2 <= '0;
            filt  <= '0;
        end else begin
            hist1 <= sync2;
            hist2 <= hist1;
            filt  <= filt_next;
        end
    end

    assign ev = filt_next & ~filt;
`else
    logic [1:0] prev;

    // Previous-value register for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= '0;
        else        prev <= sync2;
    end

    assign ev = sync2 & ~prev;
`endif

    assign zero_start = (state == IDLE) && zero_req;

    // Zeroing FSM state and down-counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            zcnt  <= '0;
        end else begin
            state <= state_next;
            zcnt  <= zcnt_next;
        end
    end

    // Zeroing FSM next state: hold ZEROING for exactly ZERO_LEN cycles
    always_comb begin
        state_next = state;
        zcnt_next  = zcnt;
        case (state)
            IDLE: begin
                if (zero_req) begin
                    state_next = ZEROING;
                    zcnt_next  = ZW'(ZERO_LEN);
                end
            end
            ZEROING: begin
                if (zcnt == ZW'(1)) begin
                    state_next = IDLE;
                    zcnt_next  = '0;
                end else begin
                    zcnt_next = zcnt - ZW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign CCDUZ = (state == ZEROING);
    assign busy  = (state == ZEROING);

    // Counter next value; simultaneous plus and minus cancel, zeroing wins
    always_comb begin
        cnt_next  = cnt;
        wrap_next = 1'b0;
        if (zero_start || (state == ZEROING)) begin
            cnt_next = '0;
        end else if (ev[0] && !ev[1]) begin
            cnt_next  = cnt + CNT_W'(1);
            wrap_next = (cnt == MID_M1);
        end else if (ev[1] && !ev[0]) begin
            cnt_next  = cnt - CNT_W'(1);
            wrap_next = (cnt == MID);
        end
    end

    // Counter, wrap strobe and snapshot read registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            wrap    <= 1'b0;
            rd_ack  <= 1'b0;
            rd_data <= '0;
        end else begin
            cnt    <= cnt_next;
            wrap   <= wrap_next;
            rd_ack <= rd_req;
            if (rd_req) rd_data <= cnt_next;
        end
    end

endmodule

// File: tb/tb_cdu_count_receiver.sv
// tb/tb_cdu_count_receiver.sv - randomized self-checking bench for cdu_count_receiver
module tb_cdu_count_receiver;

    localparam int HALF = 500;
    localparam int ZL   = 2048;
    localparam int CW   = 10;
    localparam int MOD  = 1 << CW;
    localparam int MIDV = 1 << (CW - 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          PCDU = 1'b0, MCDU = 1'b0, zero_req = 1'b0, rd_req = 1'b0;
    logic          CLOCKH, CCDUZ, busy, rd_ack, wrap;
    logic [CW-1:0] rd_data;

    int checks = 0, failures = 0;
    int model = 0, model_wraps = 0;
    int wrap_seen = 0, wrap_multi = 0;
    logic wrap_prev = 1'b0;

    cdu_count_receiver #(.CLKH_HALF_DIV(HALF), .ZERO_LEN(ZL), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .PCDU(PCDU), .MCDU(MCDU), .zero_req(zero_req),
        .rd_req(rd_req), .CLOCKH(CLOCKH), .CCDUZ(CCDUZ), .busy(busy),
        .rd_ack(rd_ack), .rd_data(rd_data), .wrap(wrap)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wrap) wrap_seen++;
        if (wrap && wrap_prev) wrap_multi++;
        wrap_prev = wrap;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // one pulse on the chosen pins; model follows the counting rules when counts=1
    task automatic pulse(input bit p, input bit m, input int hi, input int lo, input bit counts);
        @(negedge clk);
        PCDU = p; MCDU = m;
        repeat (hi) @(negedge clk);
        PCDU = 1'b0; MCDU = 1'b0;
        repeat (lo) @(negedge clk);
        if (counts && (p != m)) begin
            if (p && model == MIDV - 1) model_wraps++;
            if (m && model == MIDV)     model_wraps++;
            model = p ? (model + 1) % MOD : (model + MOD - 1) % MOD;
        end
    endtask

    task automatic do_read(input string tag);
        @(negedge clk); rd_req = 1'b1;
        @(negedge clk); rd_req = 1'b0;
        check({tag, "_ack"}, rd_ack, 1);
        check({tag, "_data"}, rd_data, model);
    endtask

    task automatic do_zero();
        int n;
        @(negedge clk); zero_req = 1'b1;
        @(negedge clk); zero_req = 1'b0;
        n = 0;
        while (busy && n < ZL + 20) begin @(negedge clk); n++; end
        if (busy) check("zero_timeout", busy, 0);
        model = 0;
    endtask

    initial begin
        int k, exp_clk, toggles, clk_err, other_err;
        int i, bcyc, cz_err;
        logic last_clk;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_clockh", CLOCKH, 0);
        check("rst_ccduz", CCDUZ, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_ack", rd_ack, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_wrap", wrap, 0);

        // CLOCKH period after release
        rst_n = 1'b1;
        toggles = 0; clk_err = 0; other_err = 0; last_clk = 1'b0;
        for (k = 1; k <= 2 * HALF * 4; k++) begin
            @(posedge clk); #1;
            exp_clk = (k / HALF) % 2;
            if (CLOCKH !== exp_clk[0]) clk_err++;
            if (CLOCKH !== last_clk) toggles++;
            last_clk = CLOCKH;
            if (CCDUZ || busy || rd_ack || wrap || (rd_data != 0)) other_err++;
        end
        check("clockh_phase_errs", clk_err, 0);
        check("clockh_toggles", toggles, 8);
        check("idle_outputs_errs", other_err, 0);

        // 10 plus then 3 minus
        repeat (10) pulse(1, 0, 3, 4, 1);
        repeat (3)  pulse(0, 1, 3, 4, 1);
        do_read("p10m3");
        check("p10m3_value", rd_data, 7);

        // back-to-back reads
        @(negedge clk); rd_req = 1'b1;
        @(negedge clk); check("b2b_ack1", rd_ack, 1);
        @(negedge clk); rd_req = 1'b0; check("b2b_ack2", rd_ack, 1);
        @(negedge clk); check("b2b_ack3", rd_ack, 0);
        check("rd_data_hold", rd_data, 7);

        // simultaneous plus and minus cancel
        repeat (5) pulse(1, 1, 3, 4, 1);
        do_read("both");

        // zero window with ignored pulses, mid-window read and repeated zero_req
        do_zero();
        repeat (MIDV > 291 ? 291 : MIDV - 2) pulse(1, 0, 3, 4, 1);
        do_read("pre_zero");
        @(negedge clk); zero_req = 1'b1;
        @(negedge clk); zero_req = 1'b0;
        model = 0;
        i = 0; bcyc = 0; cz_err = 0;
        while (busy && i < 5000) begin
            bcyc++;
            if (CCDUZ !== busy) cz_err++;
            if (i == 10) PCDU = 1'b1;
            if (i == 14) PCDU = 1'b0;
            if (i == 30) rd_req = 1'b1;
            if (i == 31) begin
                rd_req = 1'b0;
                check("zeroing_rd_ack", rd_ack, 1);
                check("zeroing_rd_data", rd_data, 0);
            end
            if (i == 1000) zero_req = 1'b1;
            if (i == 1001) zero_req = 1'b0;
            @(negedge clk); i++;
        end
        check("busy_len", bcyc, ZL);
        check("ccduz_eq_busy_errs", cz_err, 0);
        check("ccduz_after", CCDUZ, 0);
        pulse(1, 0, 3, 4, 1);
        do_read("post_zero");

        // wrap at the signed midpoint in both directions, none at 0 -> all ones
        while (model != MIDV - 1) pulse(1, 0, 3, 4, 1);
        check("pre_wrap_none", wrap_seen, model_wraps);
        pulse(1, 0, 3, 4, 1);
        do_read("wrap_up");
        check("wrap_up_count", wrap_seen, model_wraps);
        pulse(0, 1, 3, 4, 1);
        do_read("wrap_dn");
        check("wrap_dn_count", wrap_seen, 2);
        do_zero();
        pulse(0, 1, 3, 4, 1);
        do_read("zero_to_ones");
        check("no_wrap_at_zero", wrap_seen, 2);

        // randomized pulses against the model
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 2))
                0: pulse(1, 0, $urandom_range(3, 5), $urandom_range(4, 6), 1);
                1: pulse(0, 1, $urandom_range(3, 5), $urandom_range(4, 6), 1);
                default: pulse(1, 1, $urandom_range(3, 5), $urandom_range(4, 6), 1);
            endcase
            if (n % 20 == 19) do_read("rand");
        end
        check("rand_wraps", wrap_seen, model_wraps);
        check("wrap_single_cycle", wrap_multi, 0);

`ifdef CDU_GLITCH_FILTER_EN
        pulse(1, 0, 2, 6, 0);
        do_read("glitch2");
        pulse(1, 0, 4, 6, 1);
        do_read("pulse4");
`endif

        // asynchronous reset in the middle of zeroing
        @(negedge clk); zero_req = 1'b1;
        @(negedge clk); zero_req = 1'b0;
        repeat (100) @(negedge clk);
        check("mid_zero_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ccduz", CCDUZ, 0);
        check("async_rst_busy", busy, 0);
        @(negedge clk); rst_n = 1'b1;
        model = 0;
        do_read("after_rst");
        pulse(1, 0, 3, 4, 1);
        do_read("after_rst_count");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
